// File: rtl/phys_reg_writeback.sv
// rtl/phys_reg_writeback.sv - writeback buffer and ready scoreboard for the physical register file
module phys_reg_writeback #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int FIFO_DEPTH    = 4,
  localparam int LOG_PHYS     = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     AluValid_IN,
  input  logic [LOG_PHYS-1:0]      AluReg_IN,
  input  logic [31:0]              AluData_IN,
  output logic                     AluReady_OUT,
  input  logic                     MemValid_IN,
  input  logic [LOG_PHYS-1:0]      MemReg_IN,
  input  logic [31:0]              MemData_IN,
  output logic                     MemReady_OUT,
  input  logic                     Alloc_IN,
  input  logic [LOG_PHYS-1:0]      AllocReg_IN,
  output logic [LOG_PHYS-1:0]      RegWrite_OUT,
  output logic [31:0]              DataWrite_OUT,
  output logic                     Write_OUT,
  output logic [NUM_PHYS_REGS-1:0] RegReady_OUT,
  output logic [CNT_W-1:0]         Count_OUT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [LOG_PHYS-1:0]      reg_mem  [FIFO_DEPTH];
  logic [31:0]              data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         tail_alu;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         free;
  logic                     mem_push;
  logic                     alu_push;
  logic                     pop;
  logic [NUM_PHYS_REGS-1:0] reg_ready;

  // Space is judged from the registered count only; MEM gets the last slot.
  assign free         = DEPTH_C - count;
  assign MemReady_OUT = (free != '0);
  assign AluReady_OUT = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !MemValid_IN);

  assign mem_push = MemValid_IN && MemReady_OUT;
  assign alu_push = AluValid_IN && AluReady_OUT;
  assign pop      = (count != '0);

  // ALU lands behind MEM when both are accepted in the same cycle.
  assign tail_alu = mem_push ? tail + PTR_W'(1) : tail;

  // Head entry drives the register-file write port; the file never stalls.
  assign Write_OUT     = pop;
  assign RegWrite_OUT  = pop ? reg_mem[head]  : '0;
  assign DataWrite_OUT = pop ? data_mem[head] : '0;
  assign RegReady_OUT  = reg_ready;
  assign Count_OUT     = count;

  // Entry storage; contents are meaningless outside head..tail so no reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (mem_push) begin
        reg_mem[tail]  <= MemReg_IN;
        data_mem[tail] <= MemData_IN;
      end
      if (alu_push) begin
        reg_mem[tail_alu]  <= AluReg_IN;
        data_mem[tail_alu] <= AluData_IN;
      end
    end
  end

  // Circular-buffer pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
      count <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  // Ready scoreboard: a write marks its register final, a newer allocation clears it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      reg_ready <= '1;
    end else begin
      if (pop) begin
        reg_ready[RegWrite_OUT] <= 1'b1;
      end
      if (Alloc_IN) begin
        reg_ready[AllocReg_IN] <= 1'b0;
      end
    end
  end

endmodule
